// File: rtl/fnd_display_arbiter_if.sv
// ---------------------------------------------------------------------------
// fnd_display_arbiter_if
//
// Purpose:
//   Bundles the data and handshake signals that run between the FND display
//   arbiter and its neighbours. The neighbours are the BLDC PI controller,
//   the protection logic and the FND controller. Clock and reset are not
//   part of the bundle; they stay plain ports on the arbiter.
//
// Signals:
//   i_speed_value     [15:0]  live motor speed, hex
//   i_setpoint_value  [15:0]  current setpoint
//   i_setpoint_strobe         one-cycle pulse, setpoint changed
//   i_fault                   fault level from protection logic
//   i_fault_code      [15:0]  fault code, valid while i_fault=1
//   i_fault_clear             one-cycle fault clear request
//   o_value           [15:0]  value shown on the FND (registered)
//   o_src             [1:0]   0=speed, 1=setpoint, 2=fault
//   o_blank                   1 blanks every digit
//   o_fault_latched           sticky fault flag
//
// Modports:
//   master : upstream/downstream side (drives i_*, observes o_*)
//   slave  : the arbiter itself (reads i_*, drives o_*)
// ---------------------------------------------------------------------------
interface fnd_display_arbiter_if;

    logic [15:0] i_speed_value;
    logic [15:0] i_setpoint_value;
    logic        i_setpoint_strobe;
    logic        i_fault;
    logic [15:0] i_fault_code;
    logic        i_fault_clear;

    logic [15:0] o_value;
    logic [1:0]  o_src;
    logic        o_blank;
    logic        o_fault_latched;

    modport master (
        output i_speed_value,
        output i_setpoint_value,
        output i_setpoint_strobe,
        output i_fault,
        output i_fault_code,
        output i_fault_clear,
        input  o_value,
        input  o_src,
        input  o_blank,
        input  o_fault_latched
    );

    modport slave (
        input  i_speed_value,
        input  i_setpoint_value,
        input  i_setpoint_strobe,
        input  i_fault,
        input  i_fault_code,
        input  i_fault_clear,
        output o_value,
        output o_src,
        output o_blank,
        output o_fault_latched
    );

endinterface

// File: rtl/fnd_display_arbiter.sv
// ---------------------------------------------------------------------------
// fnd_display_arbiter
//
// Purpose:
//   Chooses the 16-bit value that drives the 4-digit FND controller, and
//   decides when that value changes. There are three sources:
//     - live speed: the default. It is resampled once per refresh period so
//       the digits stay readable.
//     - setpoint overlay: shown for a hold time after the last setpoint
//       strobe, then the display falls back to speed.
//     - fault code: sticky and blinking. It stays until an explicit clear
//       arrives while the fault input is low.
//   Every output is registered. A decision taken in one cycle appears on
//   the outputs at the next rising edge.
//
// Parameters:
//   REFRESH_CYCLES  period between speed samples
//   HOLD_CYCLES     setpoint overlay duration after the last strobe
//   BLINK_CYCLES    fault blink half-period
//   CNT_W           counter width, must hold max(...)-1 of the above
//
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous, active-low reset
//   bus      fnd_display_arbiter_if.slave (data inputs, display outputs)
// ---------------------------------------------------------------------------
module fnd_display_arbiter #(
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int HOLD_CYCLES    = 200_000_000,
    parameter int BLINK_CYCLES   = 25_000_000,
    parameter int CNT_W          = 28
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    fnd_display_arbiter_if.slave        bus
);

    // The state encoding doubles as the o_src code, so o_src can be driven
    // straight from the state register. Code 3 is never reached.
    typedef enum logic [1:0] {
        ST_SPEED    = 2'd0,
        ST_SETPOINT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // Terminal counts. Every counter wraps at these values, never at 2^CNT_W.
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] refresh_cnt;
    logic [CNT_W-1:0] refresh_cnt_nx;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nx;
    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] blink_cnt_nx;
    logic [15:0]      value_q;
    logic [15:0]      value_nx;
    logic             blank_q;
    logic             blank_nx;
    logic             latched_q;
    logic             latched_nx;

    // State and output registers. Reset is asynchronous, so a reset in the
    // middle of operation clears everything at once, including a latched
    // fault and its captured code.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_SPEED;
            refresh_cnt <= '0;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            value_q     <= 16'h0000;
            blank_q     <= 1'b0;
            latched_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            refresh_cnt <= refresh_cnt_nx;
            hold_cnt    <= hold_cnt_nx;
            blink_cnt   <= blink_cnt_nx;
            value_q     <= value_nx;
            blank_q     <= blank_nx;
            latched_q   <= latched_nx;
        end
    end

    // Next-state and next-output logic.
    //
    // A new fault is checked first and beats a strobe or clear in the same
    // cycle. Once the latch is set, the fault input is ignored until the
    // fault is cleared, so the first captured code stays on the display.
    //
    // Only the counter that belongs to the current state advances. The
    // other two counters are parked at zero, which also gives each state
    // the "restart at 0 on entry" behaviour with no extra logic.
    //
    // Blank defaults to 0 and is held only inside FAULT, so every exit
    // from FAULT un-blanks the display on the same edge.
    always_comb begin
        state_nx       = state;
        refresh_cnt_nx = '0;
        hold_cnt_nx    = '0;
        blink_cnt_nx   = '0;
        value_nx       = value_q;
        blank_nx       = 1'b0;
        latched_nx     = latched_q;

        if (bus.i_fault && !latched_q) begin
            state_nx   = ST_FAULT;
            value_nx   = bus.i_fault_code;
            latched_nx = 1'b1;
        end else begin
            unique case (state)
                ST_SPEED: begin
                    if (bus.i_setpoint_strobe) begin
                        state_nx = ST_SETPOINT;
                        value_nx = bus.i_setpoint_value;
                    end else if (refresh_cnt == REFRESH_LAST) begin
                        value_nx = bus.i_speed_value;
                    end else begin
                        refresh_cnt_nx = refresh_cnt + CNT_ONE;
                    end
                end

                ST_SETPOINT: begin
                    // A repeated strobe reloads the value and restarts the
                    // hold. Setpoint changes without a strobe are not shown.
                    if (bus.i_setpoint_strobe) begin
                        value_nx = bus.i_setpoint_value;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nx = ST_SPEED;
                        value_nx = bus.i_speed_value;
                    end else begin
                        hold_cnt_nx = hold_cnt + CNT_ONE;
                    end
                end

                ST_FAULT: begin
                    // A clear is honoured only after the protection logic
                    // has dropped the fault. Strobes seen here are dropped,
                    // not queued.
                    if (bus.i_fault_clear && !bus.i_fault) begin
                        state_nx   = ST_SPEED;
                        value_nx   = bus.i_speed_value;
                        latched_nx = 1'b0;
                    end else begin
                        blank_nx = blank_q;
                        if (blink_cnt == BLINK_LAST) begin
                            blank_nx = ~blank_q;
                        end else begin
                            blink_cnt_nx = blink_cnt + CNT_ONE;
                        end
                    end
                end

                default: begin
                    // The unused encoding falls back to the speed display.
                    state_nx   = ST_SPEED;
                    value_nx   = bus.i_speed_value;
                    latched_nx = 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers. o_src is the state register
    // itself, so it changes on the same edge as the state.
    assign bus.o_value         = value_q;
    assign bus.o_src           = state;
    assign bus.o_blank         = blank_q;
    assign bus.o_fault_latched = latched_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fnd_display_arbiter
//
// Purpose:
//   Self-checking bench for fnd_display_arbiter. It uses short timing
//   parameters: REFRESH=4, HOLD=10, BLINK=3. Directed scenarios cover
//   refresh, setpoint overlay, fault latch/blink/clear and asynchronous
//   reset. A randomized run is then checked against a behavioural model
//   that tracks "edges since entry" for each display mode.
// ---------------------------------------------------------------------------
module tb_fnd_display_arbiter;

    localparam int R = 4;
    localparam int H = 10;
    localparam int B = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Expected o_blank on the fault entry edge and the six edges after it.
    logic exp_blank [7];

    // Behavioural model state: mode 0/1/2, value shown, edges since the
    // mode began (or since the last strobe), and the fault latch.
    int          m_mode;
    logic [15:0] m_value;
    int          m_age;
    logic        m_latched;
    logic        m_blank;

    fnd_display_arbiter_if bus();

    fnd_display_arbiter #(
        .REFRESH_CYCLES(R),
        .HOLD_CYCLES   (H),
        .BLINK_CYCLES  (B),
        .CNT_W         (28)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Guards against the run ever hanging.
    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one rising edge, then settle 1 time unit past it so outputs
    // are sampled and inputs are driven away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every data input to its idle value.
    task automatic idle_inputs();
        bus.i_speed_value     = 16'h0000;
        bus.i_setpoint_value  = 16'h0000;
        bus.i_setpoint_strobe = 1'b0;
        bus.i_fault           = 1'b0;
        bus.i_fault_code      = 16'h0000;
        bus.i_fault_clear     = 1'b0;
    endtask

    // Reference model: one rising edge, using the inputs currently driven.
    task automatic model_edge();
        if (m_mode != 2 && bus.i_fault) begin
            m_mode    = 2;
            m_value   = bus.i_fault_code;
            m_age     = 0;
            m_latched = 1'b1;
        end else begin
            case (m_mode)
                0: begin
                    if (bus.i_setpoint_strobe) begin
                        m_mode  = 1;
                        m_value = bus.i_setpoint_value;
                        m_age   = 0;
                    end else begin
                        m_age = m_age + 1;
                        if (m_age % R == 0) m_value = bus.i_speed_value;
                    end
                end
                1: begin
                    if (bus.i_setpoint_strobe) begin
                        m_value = bus.i_setpoint_value;
                        m_age   = 0;
                    end else begin
                        m_age = m_age + 1;
                        if (m_age == H) begin
                            m_mode  = 0;
                            m_value = bus.i_speed_value;
                            m_age   = 0;
                        end
                    end
                end
                default: begin
                    if (bus.i_fault_clear && !bus.i_fault) begin
                        m_mode    = 0;
                        m_value   = bus.i_speed_value;
                        m_age     = 0;
                        m_latched = 1'b0;
                    end else begin
                        m_age = m_age + 1;
                    end
                end
            endcase
        end
        m_blank = (m_mode == 2) && (((m_age / B) % 2) == 1);
    endtask

    // Reset state, then the first refresh load at edge 4 after release.
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.i_speed_value = 16'h1234;
        tick();
        tick();
        total++; if (bus.o_value !== 16'h0000) begin bad++; $display("[TB] FAIL reset_value: got %h want %h", bus.o_value, 16'h0000); end
        total++; if (bus.o_src !== 2'd0) begin bad++; $display("[TB] FAIL reset_src: got %0d want %0d", bus.o_src, 0); end
        total++; if (bus.o_blank !== 1'b0) begin bad++; $display("[TB] FAIL reset_blank: got %b want %b", bus.o_blank, 1'b0); end
        total++; if (bus.o_fault_latched !== 1'b0) begin bad++; $display("[TB] FAIL reset_latched: got %b want %b", bus.o_fault_latched, 1'b0); end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (bus.o_value !== 16'h0000 || bus.o_src !== 2'd0) begin bad++; $display("[TB] FAIL pre_refresh edge %0d: got %h/%0d want 0000/0", k, bus.o_value, bus.o_src); end
        end
        tick();
        total++; if (bus.o_value !== 16'h1234) begin bad++; $display("[TB] FAIL first_refresh: got %h want %h", bus.o_value, 16'h1234); end
    endtask

    // A speed change mid-period shows only at the next terminal count.
    task automatic test_refresh();
        tick();
        bus.i_speed_value = 16'h5678;
        for (int k = 6; k <= 7; k++) begin
            tick();
            total++; if (bus.o_value !== 16'h1234) begin bad++; $display("[TB] FAIL refresh_hold edge %0d: got %h want %h", k, bus.o_value, 16'h1234); end
        end
        tick();
        total++; if (bus.o_value !== 16'h5678) begin bad++; $display("[TB] FAIL refresh_second: got %h want %h", bus.o_value, 16'h5678); end
    endtask

    // Setpoint overlay, restart on a second strobe, timeout back to speed.
    task automatic test_setpoint();
        bus.i_setpoint_value  = 16'h00A0;
        bus.i_setpoint_strobe = 1'b1;
        tick();
        bus.i_setpoint_strobe = 1'b0;
        total++; if (bus.o_value !== 16'h00A0 || bus.o_src !== 2'd1) begin bad++; $display("[TB] FAIL setpoint_entry: got %h/%0d want 00a0/1", bus.o_value, bus.o_src); end
        bus.i_setpoint_value = 16'h00C0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (bus.o_value !== 16'h00A0) begin bad++; $display("[TB] FAIL setpoint_no_strobe %0d: got %h want %h", k, bus.o_value, 16'h00A0); end
        end
        bus.i_setpoint_value  = 16'h00B0;
        bus.i_setpoint_strobe = 1'b1;
        tick();
        bus.i_setpoint_strobe = 1'b0;
        bus.i_speed_value     = 16'h9ABC;
        total++; if (bus.o_value !== 16'h00B0 || bus.o_src !== 2'd1) begin bad++; $display("[TB] FAIL setpoint_restrobe: got %h/%0d want 00b0/1", bus.o_value, bus.o_src); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++; if (bus.o_value !== 16'h00B0 || bus.o_src !== 2'd1) begin bad++; $display("[TB] FAIL setpoint_hold %0d: got %h/%0d want 00b0/1", k, bus.o_value, bus.o_src); end
        end
        tick();
        total++; if (bus.o_value !== 16'h9ABC || bus.o_src !== 2'd0) begin bad++; $display("[TB] FAIL setpoint_timeout: got %h/%0d want 9abc/0", bus.o_value, bus.o_src); end
    endtask

    // Fault beats a simultaneous strobe, the code is kept, blink sequence.
    task automatic test_fault_entry();
        bus.i_fault           = 1'b1;
        bus.i_fault_code      = 16'h0E01;
        bus.i_setpoint_value  = 16'h1111;
        bus.i_setpoint_strobe = 1'b1;
        tick();
        bus.i_setpoint_strobe = 1'b0;
        bus.i_fault_code      = 16'h0E02;
        total++; if (bus.o_src !== 2'd2 || bus.o_value !== 16'h0E01) begin bad++; $display("[TB] FAIL fault_entry: got %h/%0d want 0e01/2", bus.o_value, bus.o_src); end
        total++; if (bus.o_fault_latched !== 1'b1) begin bad++; $display("[TB] FAIL fault_latched: got %b want %b", bus.o_fault_latched, 1'b1); end
        total++; if (bus.o_blank !== exp_blank[0]) begin bad++; $display("[TB] FAIL blink step 0: got %b want %b", bus.o_blank, exp_blank[0]); end
        for (int k = 1; k < 7; k++) begin
            tick();
            total++; if (bus.o_blank !== exp_blank[k] || bus.o_value !== 16'h0E01) begin bad++; $display("[TB] FAIL blink step %0d: got %b/%h want %b/0e01", k, bus.o_blank, bus.o_value, exp_blank[k]); end
        end
    endtask

    // A clear while the fault is still active is ignored; after it drops, a clear works.
    task automatic test_fault_clear();
        bus.i_fault_clear = 1'b1;
        tick();
        bus.i_fault_clear = 1'b0;
        total++; if (bus.o_src !== 2'd2 || bus.o_fault_latched !== 1'b1) begin bad++; $display("[TB] FAIL clear_ignored: got %0d/%b want 2/1", bus.o_src, bus.o_fault_latched); end
        bus.i_fault = 1'b0;
        tick();
        total++; if (bus.o_src !== 2'd2) begin bad++; $display("[TB] FAIL fault_sticky: got %0d want %0d", bus.o_src, 2); end
        bus.i_speed_value = 16'h4321;
        bus.i_fault_clear = 1'b1;
        tick();
        bus.i_fault_clear = 1'b0;
        total++; if (bus.o_src !== 2'd0 || bus.o_blank !== 1'b0) begin bad++; $display("[TB] FAIL clear_exit: got %0d/%b want 0/0", bus.o_src, bus.o_blank); end
        total++; if (bus.o_value !== 16'h4321 || bus.o_fault_latched !== 1'b0) begin bad++; $display("[TB] FAIL clear_value: got %h/%b want 4321/0", bus.o_value, bus.o_fault_latched); end
    endtask

    // A strobe during a fault is not queued: the clear returns to speed.
    task automatic test_strobe_in_fault();
        bus.i_fault      = 1'b1;
        bus.i_fault_code = 16'h0F0F;
        tick();
        bus.i_fault           = 1'b0;
        bus.i_setpoint_value  = 16'h2222;
        bus.i_setpoint_strobe = 1'b1;
        tick();
        bus.i_setpoint_strobe = 1'b0;
        total++; if (bus.o_src !== 2'd2 || bus.o_value !== 16'h0F0F) begin bad++; $display("[TB] FAIL strobe_in_fault: got %h/%0d want 0f0f/2", bus.o_value, bus.o_src); end
        tick();
        bus.i_speed_value = 16'h5555;
        bus.i_fault_clear = 1'b1;
        tick();
        bus.i_fault_clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.o_src !== 2'd0 || bus.o_value !== 16'h5555) begin bad++; $display("[TB] FAIL no_queued_strobe %0d: got %h/%0d want 5555/0", k, bus.o_value, bus.o_src); end
            tick();
        end
    endtask

    // Asynchronous reset while blanked clears outputs with no clock edge.
    task automatic test_async_reset();
        bus.i_fault      = 1'b1;
        bus.i_fault_code = 16'h0ABC;
        tick();
        bus.i_fault = 1'b0;
        tick();
        tick();
        tick();
        total++; if (bus.o_blank !== 1'b1) begin bad++; $display("[TB] FAIL blank_before_reset: got %b want %b", bus.o_blank, 1'b1); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_value !== 16'h0000 || bus.o_src !== 2'd0) begin bad++; $display("[TB] FAIL async_reset_value: got %h/%0d want 0000/0", bus.o_value, bus.o_src); end
        total++; if (bus.o_blank !== 1'b0 || bus.o_fault_latched !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_flags: got %b/%b want 0/0", bus.o_blank, bus.o_fault_latched); end
        tick();
        rst_n = 1'b1;
    endtask

    // Randomized traffic checked every cycle against the behavioural model.
    task automatic test_random();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        m_mode    = 0;
        m_value   = 16'h0000;
        m_age     = 0;
        m_latched = 1'b0;
        m_blank   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bus.i_speed_value     = 16'($urandom);
            bus.i_setpoint_value  = 16'($urandom);
            bus.i_setpoint_strobe = ($urandom_range(7) == 0);
            bus.i_fault           = ($urandom_range(11) == 0);
            bus.i_fault_code      = 16'($urandom);
            bus.i_fault_clear     = ($urandom_range(5) == 0);
            model_edge();
            tick();
            total++; if (bus.o_value !== m_value || bus.o_src !== 2'(m_mode)) begin bad++; $display("[TB] FAIL random value/src cycle %0d: got %h/%0d want %h/%0d", n, bus.o_value, bus.o_src, m_value, m_mode); end
            total++; if (bus.o_blank !== m_blank || bus.o_fault_latched !== m_latched) begin bad++; $display("[TB] FAIL random blank/latched cycle %0d: got %b/%b want %b/%b", n, bus.o_blank, bus.o_fault_latched, m_blank, m_latched); end
        end
    endtask

    initial begin
        exp_blank[0] = 1'b0;
        exp_blank[1] = 1'b0;
        exp_blank[2] = 1'b0;
        exp_blank[3] = 1'b1;
        exp_blank[4] = 1'b1;
        exp_blank[5] = 1'b1;
        exp_blank[6] = 1'b0;
        $display("[TB] starting fnd_display_arbiter bench");
        test_reset();
        test_refresh();
        test_setpoint();
        test_fault_entry();
        test_fault_clear();
        test_strobe_in_fault();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_display_arbiter.md
Name: fnd_display_arbiter

Overview:
- Decides which 16-bit value drives the 4-digit FND display controller, and when that value changes.
- Three sources share the display: live motor speed (default), setpoint overlay (temporary, after a setpoint change) and fault code (sticky, blinking).
- Sits between the BLDC PI controller / fault logic and the FND controller; its o_value feeds the FND controller's i_value and its o_blank gates the segment outputs.
- Rate-limits speed updates so the digits stay readable.

Parameters:
- REFRESH_CYCLES, 5_000_000: period between speed samples (50 ms at 100 MHz).
- HOLD_CYCLES, 200_000_000: setpoint overlay duration after the last strobe (2 s).
- BLINK_CYCLES, 25_000_000: fault blink half-period.
- CNT_W, 28: counter width; must hold max(REFRESH, HOLD, BLINK)-1.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_speed_value  in  16  live speed, hex
- i_setpoint_value  in  16  current setpoint
- i_setpoint_strobe  in  1  one-cycle pulse: setpoint changed
- i_fault  in  1  fault level from protection logic
- i_fault_code  in  16  code valid while i_fault=1
- i_fault_clear  in  1  one-cycle clear request
- o_value  out  16  value to FND controller, registered
- o_src  out  2  0=speed, 1=setpoint, 2=fault; 3 never driven
- o_blank  out  1  1 = FND controller blanks all digits
- o_fault_latched  out  1  sticky fault flag

Behaviour:
- Reset (i_reset=0, async): state SPEED; o_value=0, o_src=0, o_blank=0, o_fault_latched=0; all counters 0; latched code 0. Outputs take new values only on i_clk rising edges after reset is released.
- All outputs are registered. A decision taken in cycle N appears on the outputs at edge N+1.
- State SPEED:
  - The refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
  - At terminal count, o_value <= i_speed_value.
  - On entry from another state, o_value <= i_speed_value at the first edge and the refresh counter restarts at 0.
- State SETPOINT:
  - Entered from SPEED on i_setpoint_strobe; o_value <= i_setpoint_value sampled in the strobe cycle.
  - The hold counter is cleared on entry and on every further strobe, which also reloads o_value.
  - Between strobes, o_value holds; i_setpoint_value changes without a strobe are ignored.
  - When the hold counter reaches HOLD_CYCLES-1, transition to SPEED.
- State FAULT:
  - Entered from any state in any cycle where i_fault=1 and the latch is clear. That edge sets o_fault_latched=1 and captures i_fault_code into o_value.
  - Fault has priority over a simultaneous strobe or clear.
  - While latched, further i_fault activity and code changes are ignored; the first code is kept.
  - Blink counter starts at 0 on entry with o_blank=0. o_blank toggles each time the counter reaches BLINK_CYCLES-1 (counter wraps to 0).
  - i_setpoint_strobe is ignored and not queued.
- Clearing a fault:
  - i_fault_clear=1 with i_fault=0 clears the latch and goes to SPEED: o_blank=0, o_src=0, speed loaded at that edge.
  - i_fault_clear=1 while i_fault=1 is ignored.
  - i_fault_clear in SPEED or SETPOINT has no effect.
- o_src changes on the same edge as the state change.
- o_blank is 1 only in FAULT.
- Counter wrap is modulo the terminal count, never modulo 2^CNT_W.
- Reset asserted mid-operation returns to the reset values immediately; a latched fault is lost.

Test Plan (REFRESH_CYCLES=4, HOLD_CYCLES=10, BLINK_CYCLES=3):
1. Release reset, speed=0x1234 held -> o_value=0x0000 until refresh terminal count, then 0x1234 at edge 4 after reset release; o_src=0; speed change to 0x5678 mid-period appears only at the next terminal count.
2. Strobe with setpoint=0x00A0 -> next edge o_value=0x00A0, o_src=1; second strobe at cycle 5 with 0x00B0 -> o_value=0x00B0 and the hold restarts; return to o_src=0 with current speed exactly 10 cycles after the second strobe.
3. i_fault=1, code=0x0E01, in the same cycle as a strobe -> o_src=2, o_value=0x0E01, o_fault_latched=1; o_blank sequence 0,0,0,1,1,1,0; a code change to 0x0E02 is ignored.
4. i_fault_clear while i_fault=1 -> no change. Drop i_fault, pulse clear -> next edge o_src=0, o_blank=0, o_value=live speed, o_fault_latched=0.
5. Strobe during FAULT, then clear -> goes to SPEED, not SETPOINT.
6. Assert i_reset=0 asynchronously mid-blink with o_blank=1 -> all outputs zero immediately, without waiting for a clock edge.
